// File: rtl/spi_lcd_rx.sv
// SPI receiver for an ST7789/ILI9341-style LCD command set: deserialises bytes,
// decodes CASET/PASET/RAMWR and the display-state commands into pixel writes.
module spi_lcd_rx #(
  parameter int H_RES = 240,
  parameter int V_RES = 320
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sck,
  input  logic        i_mosi,
  input  logic        i_cs,
  input  logic        i_dc,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte,
  output logic        o_byte_dc,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd,
  output logic        o_pix_valid,
  output logic [15:0] o_pix_data,
  output logic [8:0]  o_pix_x,
  output logic [8:0]  o_pix_y,
  output logic        o_disp_on,
  output logic        o_sleep_out
);

  localparam logic [8:0] XE_DEF = 9'(H_RES - 1);
  localparam logic [8:0] YE_DEF = 9'(V_RES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_IGNORE
  } state_e;

  // ---------------------------------------------------------------- front end
  // sck keeps a third stage so the edge is detected on synchronized values.
  logic [2:0] sck_sync_q;
  logic [1:0] mosi_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] dc_sync_q;

  logic sck_rise;
  logic mosi_s;
  logic cs_s;
  logic dc_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      dc_sync_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value of the previous stage.
      sck_sync_q  <= {sck_sync_q[1:0], i_sck};
      mosi_sync_q <= {mosi_sync_q[0], i_mosi};
      cs_sync_q   <= {cs_sync_q[0], i_cs};
      dc_sync_q   <= {dc_sync_q[0], i_dc};
    end
  end

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign mosi_s   = mosi_sync_q[1];
  assign cs_s     = cs_sync_q[1];
  assign dc_s     = dc_sync_q[1];

  // ------------------------------------------------------------ byte assembly
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] byte_d;
  logic       byte_valid_q;
  logic [7:0] byte_q;
  logic       byte_dc_q;
  logic       cmd_valid_q;
  logic [7:0] cmd_q;

  assign byte_d = {shift_q, mosi_s};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      byte_dc_q    <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= '0;
    end else begin
      byte_valid_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      if (cs_s) begin
        bit_cnt_q <= '0;
      end else if (sck_rise) begin
        shift_q   <= byte_d[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_q <= 1'b1;
          byte_q       <= byte_d;
          byte_dc_q    <= dc_s;
          if (!dc_s) begin
            cmd_valid_q <= 1'b1;
            cmd_q       <= byte_d;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------ decoder
  state_e      state_q;
  logic [1:0]  param_cnt_q;
  logic [8:0]  start_q;
  logic        end_hi_q;
  logic [8:0]  xs_q, xe_q, ys_q, ye_q;
  logic [8:0]  px_q, py_q;
  logic [8:0]  px_d, py_d;
  logic        hi_pend_q;
  logic [7:0]  pix_hi_q;
  logic        pix_valid_q;
  logic [15:0] pix_data_q;
  logic [8:0]  pix_x_q, pix_y_q;
  logic        disp_on_q;
  logic        sleep_out_q;

  logic [8:0]  param_end;
  logic        win_ok;

  assign param_end = {end_hi_q, byte_q};
  assign win_ok    = (start_q <= param_end);

  // Raster advance inside the current window, wrapping bottom-right to top-left.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    px_d = px_q + 9'd1;
    py_d = py_q;
    if (px_q == xe_q) begin
      px_d = xs_q;
      py_d = (py_q == ye_q) ? ys_q : py_q + 9'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      param_cnt_q <= '0;
      start_q     <= '0;
      end_hi_q    <= 1'b0;
      xs_q        <= '0;
      xe_q        <= XE_DEF;
      ys_q        <= '0;
      ye_q        <= YE_DEF;
      px_q        <= '0;
      py_q        <= '0;
      hi_pend_q   <= 1'b0;
      pix_hi_q    <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      disp_on_q   <= 1'b0;
      sleep_out_q <= 1'b0;
    end else begin
      pix_valid_q <= 1'b0;
      if (byte_valid_q && !byte_dc_q) begin
        // Any command aborts parameter collection and a pending high byte.
        hi_pend_q   <= 1'b0;
        param_cnt_q <= '0;
        case (byte_q)
          8'h2A: state_q <= ST_CASET;
          8'h2B: state_q <= ST_PASET;
          8'h2C: begin
            state_q <= ST_RAMWR;
            px_q    <= xs_q;
            py_q    <= ys_q;
          end
          8'h29: begin disp_on_q   <= 1'b1; state_q <= ST_IDLE; end
          8'h28: begin disp_on_q   <= 1'b0; state_q <= ST_IDLE; end
          8'h11: begin sleep_out_q <= 1'b1; state_q <= ST_IDLE; end
          8'h10: begin sleep_out_q <= 1'b0; state_q <= ST_IDLE; end
          8'h01: begin
            xs_q        <= '0;
            xe_q        <= XE_DEF;
            ys_q        <= '0;
            ye_q        <= YE_DEF;
            disp_on_q   <= 1'b0;
            sleep_out_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
          default: state_q <= ST_IGNORE;
        endcase
      end else if (byte_valid_q) begin
        case (state_q)
          ST_CASET, ST_PASET: begin
            param_cnt_q <= param_cnt_q + 2'd1;
            case (param_cnt_q)
              2'd0: start_q[8]   <= byte_q[0];
              2'd1: start_q[7:0] <= byte_q;
              2'd2: end_hi_q     <= byte_q[0];
              default: begin
                if (win_ok && state_q == ST_CASET) begin
                  xs_q <= start_q;
                  xe_q <= param_end;
                end else if (win_ok) begin
                  ys_q <= start_q;
                  ye_q <= param_end;
                end
                state_q <= ST_IGNORE;
              end
            endcase
          end
          ST_RAMWR: begin
            if (!hi_pend_q) begin
              pix_hi_q  <= byte_q;
              hi_pend_q <= 1'b1;
            end else begin
              hi_pend_q   <= 1'b0;
              pix_valid_q <= 1'b1;
              pix_data_q  <= {pix_hi_q, byte_q};
              pix_x_q     <= px_q;
              pix_y_q     <= py_q;
              px_q        <= px_d;
              py_q        <= py_d;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_byte_valid = byte_valid_q;
  assign o_byte       = byte_q;
  assign o_byte_dc    = byte_dc_q;
  assign o_cmd_valid  = cmd_valid_q;
  assign o_cmd        = cmd_q;
  assign o_pix_valid  = pix_valid_q;
  assign o_pix_data   = pix_data_q;
  assign o_pix_x      = pix_x_q;
  assign o_pix_y      = pix_y_q;
  assign o_disp_on    = disp_on_q;
  assign o_sleep_out  = sleep_out_q;

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Bench for spi_lcd_rx: drives SPI traffic, scoreboards bytes/commands/pixels
// against expectations queued at drive time, and checks display flags.
`timescale 1ns/1ps
module tb_spi_lcd_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        cs = 1'b1;
  logic        dc = 1'b1;
  logic        byte_valid;
  logic [7:0]  byte_out;
  logic        byte_dc;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [8:0]  pix_x, pix_y;
  logic        disp_on, sleep_out;

  int total = 0;
  int bad   = 0;

  logic [8:0]  byte_q[$];
  logic [7:0]  cmd_q[$];
  logic [33:0] pix_q[$];

  always #5 clk = ~clk;

  spi_lcd_rx #(.H_RES(240), .V_RES(320)) dut (
    .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_mosi(mosi), .i_cs(cs), .i_dc(dc),
    .o_byte_valid(byte_valid), .o_byte(byte_out), .o_byte_dc(byte_dc),
    .o_cmd_valid(cmd_valid), .o_cmd(cmd),
    .o_pix_valid(pix_valid), .o_pix_data(pix_data), .o_pix_x(pix_x), .o_pix_y(pix_y),
    .o_disp_on(disp_on), .o_sleep_out(sleep_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: pop and compare whenever the DUT strobes an output.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) begin
        if (byte_q.size() == 0) check("byte_unexpected", byte_q.size(), 1);
        else check("byte", {byte_dc, byte_out}, byte_q.pop_front());
      end
      if (cmd_valid) begin
        check("cmd_with_byte", byte_valid, 1'b1);
        if (cmd_q.size() == 0) check("cmd_unexpected", cmd_q.size(), 1);
        else check("cmd", cmd, cmd_q.pop_front());
      end
      if (pix_valid) begin
        if (pix_q.size() == 0) check("pix_unexpected", pix_q.size(), 1);
        else check("pix", {pix_data, pix_x, pix_y}, pix_q.pop_front());
      end
    end
  end

  task automatic spi_bits(input logic d, input logic [7:0] b, input int n);
    if (cs) begin
      cs = 1'b0;
      wait_clk(4);
    end
    dc = d;
    for (int i = 7; i >= 8 - n; i--) begin
      mosi = b[i];
      wait_clk(2);
      sck = 1'b1;
      wait_clk(2);
      sck = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    byte_q.push_back({1'b0, b});
    cmd_q.push_back(b);
    spi_bits(1'b0, b, 8);
  endtask

  task automatic send_data(input logic [7:0] b);
    byte_q.push_back({1'b1, b});
    spi_bits(1'b1, b, 8);
  endtask

  task automatic exp_pix(input logic [15:0] d, input logic [8:0] x, input logic [8:0] y);
    pix_q.push_back({d, x, y});
  endtask

  task automatic send_pix(input logic [15:0] d);
    send_data(d[15:8]);
    send_data(d[7:0]);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((byte_q.size() + cmd_q.size() + pix_q.size()) != 0 && n < 400) begin
      wait_clk(1);
      n++;
    end
    wait_clk(4);
    check({name, "_bytes_left"}, byte_q.size(), 0);
    check({name, "_cmds_left"}, cmd_q.size(), 0);
    check({name, "_pix_left"}, pix_q.size(), 0);
    byte_q.delete();
    cmd_q.delete();
    pix_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_strobes"}, {byte_valid, cmd_valid, pix_valid}, 3'b000);
    check({name, "_byte"}, {byte_dc, byte_out, cmd}, 17'h0);
    check({name, "_pix"}, {pix_data, pix_x, pix_y}, 34'h0);
    check({name, "_flags"}, {disp_on, sleep_out}, 2'b00);
  endtask

  typedef struct {
    logic       dc;
    logic [7:0] b;
    logic       disp;
    logic       sleep;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [8:0]  x;
    logic [8:0]  y;
  } pix_t;

  vec_t vecs[8];
  pix_t pix_tab[7];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 8'h29, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h11, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 8'h28, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h55, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h10, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h29, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h11, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 8'h01, 1'b0, 1'b0};

    pix_tab[0] = '{16'hA111, 9'd10, 9'd20};
    pix_tab[1] = '{16'hB222, 9'd11, 9'd20};
    pix_tab[2] = '{16'hC333, 9'd12, 9'd20};
    pix_tab[3] = '{16'hD444, 9'd10, 9'd21};
    pix_tab[4] = '{16'hE555, 9'd11, 9'd21};
    pix_tab[5] = '{16'hF666, 9'd12, 9'd21};
    pix_tab[6] = '{16'h0777, 9'd10, 9'd20};

    // Reset state
    wait_clk(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(4);

    // Command table: display-state flags after each byte
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].dc) send_data(vecs[i].b);
      else send_cmd(vecs[i].b);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d_disp_on", i), disp_on, vecs[i].disp);
      check($sformatf("vec%0d_sleep_out", i), sleep_out, vecs[i].sleep);
    end

    // Inverted CASET window is rejected; default window origin stays
    send_cmd(8'h2A);
    send_data(8'h00); send_data(8'h0C); send_data(8'h00); send_data(8'h0A);
    send_cmd(8'h2C);
    exp_pix(16'hBEEF, 9'd0, 9'd0);
    send_pix(16'hBEEF);
    drain("caset_reject");

    // 3x2 window, 6 pixels then wrap to the window origin
    send_cmd(8'h2A);
    send_data(8'h00); send_data(8'h0A); send_data(8'h00); send_data(8'h0C);
    send_cmd(8'h2B);
    send_data(8'h00); send_data(8'h14); send_data(8'h00); send_data(8'h15);
    send_cmd(8'h2C);
    for (int i = 0; i < 7; i++) begin
      exp_pix(pix_tab[i].d, pix_tab[i].x, pix_tab[i].y);
      send_pix(pix_tab[i].d);
    end
    drain("window");

    // Truncated CASET leaves the window unchanged
    send_cmd(8'h2A);
    send_data(8'h00); send_data(8'h01);
    send_cmd(8'h2C);
    exp_pix(16'h4321, 9'd10, 9'd20);
    send_pix(16'h4321);
    drain("caset_short");

    // cs high after 5 bits discards the partial byte
    spi_bits(1'b1, 8'hFF, 5);
    cs = 1'b1;
    wait_clk(8);
    send_data(8'hA5);
    drain("cs_abort");

    // Dangling high byte discarded by a command
    send_cmd(8'h2C);
    send_data(8'hF8);
    send_cmd(8'h00);
    send_data(8'h11); send_data(8'h22);
    drain("dangling");
    send_cmd(8'h2C);
    exp_pix(16'h1234, 9'd10, 9'd20);
    send_pix(16'h1234);
    drain("after_dangling");

    // Reset mid-pixel and mid-byte
    send_cmd(8'h29);
    send_cmd(8'h2C);
    send_data(8'hAB);
    drain("pre_reset");
    spi_bits(1'b1, 8'hCD, 4);
    rst = 1'b1;
    wait_clk(3);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    wait_clk(4);
    check_reset_outputs("post_reset");
    send_data(8'h12); send_data(8'h34);
    drain("idle_after_reset");

    // Default window after reset: one full row, then the next row start
    send_cmd(8'h2C);
    for (int i = 0; i < 241; i++) begin
      exp_pix(16'(i) ^ 16'h5A5A, 9'(i % 240), 9'(i / 240));
      send_pix(16'(i) ^ 16'h5A5A);
    end
    drain("default_window");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
